// File: rtl/blk_mem_responder.sv
// rtl/blk_mem_responder.sv - multi-cycle block backing store on the busywait cache/memory protocol
// Optional build macro MEM_STATS_EN adds RD_CNT/WR_CNT completion counters.
module blk_mem_responder #(
  parameter int ADDR_W  = 6,
  parameter int BLOCK_W = 128,
  parameter int LATENCY = 5
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               READ,
  input  logic               WRITE,
  input  logic [ADDR_W-1:0]  ADDRESS,
  input  logic [BLOCK_W-1:0] WRITEDATA,
  output logic [BLOCK_W-1:0] READDATA,
`ifdef MEM_STATS_EN
  output logic [31:0]        RD_CNT,
  output logic [31:0]        WR_CNT,
`endif
  output logic               BUSYWAIT
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  logic [1:0]         state;
  logic [7:0]         cnt;
  logic [ADDR_W-1:0]  req_addr;
  logic [BLOCK_W-1:0] req_data;
  logic               req_is_wr;
  logic               complete;

  logic [BLOCK_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Raised combinationally on request arrival so the requester never sees a false ready.
  assign BUSYWAIT = !RESET && (((state == S_IDLE) && (READ || WRITE)) || (state == S_ACCESS));
  assign complete = !RESET && (state == S_ACCESS) && (cnt == 8'd0);

  always_ff @(posedge CLK) begin
    if (complete && req_is_wr) begin
      mem[req_addr] <= req_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      cnt       <= 8'd0;
      READDATA  <= '0;
      req_is_wr <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (READ || WRITE) begin
            req_addr  <= ADDRESS;
            req_data  <= WRITEDATA;
            req_is_wr <= WRITE;
            cnt       <= CNT_INIT;
            state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            if (!req_is_wr) begin
              READDATA <= mem[req_addr];
            end
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_STATS_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      RD_CNT <= 32'd0;
      WR_CNT <= 32'd0;
    end else if (complete) begin
      if (req_is_wr) WR_CNT <= WR_CNT + 32'd1;
      else           RD_CNT <= RD_CNT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_blk_mem_responder.sv
// tb/tb_blk_mem_responder.sv - directed-vector bench for blk_mem_responder
module tb_blk_mem_responder;

  localparam logic [127:0] PAT  = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] OLD  = 128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A;
  localparam logic [127:0] NEWD = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [127:0] ONES = {128{1'b1}};

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         READ = 1'b0;
  logic         WRITE = 1'b0;
  logic [5:0]   ADDRESS = 6'd0;
  logic [127:0] WRITEDATA = '0;
  logic [127:0] READDATA;
  logic         BUSYWAIT;
`ifdef MEM_STATS_EN
  logic [31:0]  RD_CNT;
  logic [31:0]  WR_CNT;
`endif

  int n_vec = 0;
  int n_bad = 0;
  int busy_n;
  logic [127:0] rd_done;

  blk_mem_responder #(.ADDR_W(6), .BLOCK_W(128), .LATENCY(5)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .READ      (READ),
    .WRITE     (WRITE),
    .ADDRESS   (ADDRESS),
    .WRITEDATA (WRITEDATA),
    .READDATA  (READDATA),
`ifdef MEM_STATS_EN
    .RD_CNT    (RD_CNT),
    .WR_CNT    (WR_CNT),
`endif
    .BUSYWAIT  (BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with the responder idle; returns at posedge+1 after DONE.
  task automatic xfer(input logic rd, input logic wr, input logic [5:0] addr,
                      input logic [127:0] data, input int sw_cyc, input logic [5:0] sw_addr,
                      output int nbusy, output logic [127:0] rdata);
    READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = data;
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (!BUSYWAIT) break;
      nbusy++;
      if (nbusy == sw_cyc) ADDRESS = sw_addr;
    end
    rdata = READDATA;
    @(posedge CLK); #1;
    READ = 1'b0; WRITE = 1'b0;
  endtask

  // Starts a transaction and pulses reset in its k-th cycle (k counted from 1).
  task automatic aborted(input logic rd, input logic wr, input logic [5:0] addr,
                         input logic [127:0] data, input int k);
    READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = data;
    for (int i = 0; i < k; i++) @(negedge CLK);
    RESET = 1'b1;
    #1 check("abort_busy_in_reset", {127'd0, BUSYWAIT}, 128'd0);
    @(posedge CLK); #1;
    RESET = 1'b0; READ = 1'b0; WRITE = 1'b0;
    @(negedge CLK);
    check("abort_idle_busy", {127'd0, BUSYWAIT}, 128'd0);
    check("abort_readdata", READDATA, 128'd0);
    @(posedge CLK); #1;
  endtask

  initial begin
    // Reset with a request present: BUSYWAIT must stay low.
    READ = 1'b1;
    @(posedge CLK); @(negedge CLK);
    check("reset_busy", {127'd0, BUSYWAIT}, 128'd0);
    check("reset_readdata", READDATA, 128'd0);
    @(posedge CLK); #1;
    RESET = 1'b0; READ = 1'b0;

    xfer(1'b0, 1'b1, 6'h05, PAT, 0, 6'h00, busy_n, rd_done);
    check("wr05_busy_cycles", 128'(busy_n), 128'd6);
    check("wr05_readdata_untouched", READDATA, 128'd0);

    xfer(1'b1, 1'b0, 6'h05, '0, 0, 6'h00, busy_n, rd_done);
    check("rd05_busy_cycles", 128'(busy_n), 128'd6);
    check("rd05_data_in_done", rd_done, PAT);
    repeat (2) @(negedge CLK);
    check("rd05_data_held", READDATA, PAT);
    @(posedge CLK); #1;

    xfer(1'b0, 1'b1, 6'h00, 128'd0, 0, 6'h00, busy_n, rd_done);
    xfer(1'b1, 1'b0, 6'h00, '0, 2, 6'h05, busy_n, rd_done);
    check("rd00_addr_switch_ignored", rd_done, 128'd0);

    xfer(1'b0, 1'b1, 6'h0A, OLD, 0, 6'h00, busy_n, rd_done);
    aborted(1'b0, 1'b1, 6'h0A, NEWD, 3);
    xfer(1'b1, 1'b0, 6'h0A, '0, 0, 6'h00, busy_n, rd_done);
    check("rd0A_after_abort", rd_done, OLD);

    xfer(1'b1, 1'b1, 6'h3F, ONES, 0, 6'h00, busy_n, rd_done);
    check("both_hi_busy_cycles", 128'(busy_n), 128'd6);
    check("both_hi_readdata_untouched", rd_done, OLD);
    xfer(1'b1, 1'b0, 6'h3F, '0, 0, 6'h00, busy_n, rd_done);
    check("rd3F_ones", rd_done, ONES);

    xfer(1'b1, 1'b0, 6'h05, '0, 0, 6'h00, busy_n, rd_done);
    check("rd05_still_pat", rd_done, PAT);

    // Counter scenario: fresh reset, 3 writes, 2 reads, then a read aborted by reset.
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    xfer(1'b0, 1'b1, 6'h10, 128'd1, 0, 6'h00, busy_n, rd_done);
    xfer(1'b0, 1'b1, 6'h11, 128'd2, 0, 6'h00, busy_n, rd_done);
    xfer(1'b0, 1'b1, 6'h12, 128'd3, 0, 6'h00, busy_n, rd_done);
    xfer(1'b1, 1'b0, 6'h11, '0, 0, 6'h00, busy_n, rd_done);
    check("rd11", rd_done, 128'd2);
    xfer(1'b1, 1'b0, 6'h12, '0, 0, 6'h00, busy_n, rd_done);
    check("rd12", rd_done, 128'd3);
`ifdef MEM_STATS_EN
    check("stats_rd_cnt", 128'(RD_CNT), 128'd2);
    check("stats_wr_cnt", 128'(WR_CNT), 128'd3);
`endif
    aborted(1'b1, 1'b0, 6'h10, '0, 4);
`ifdef MEM_STATS_EN
    check("stats_rd_cnt_reset", 128'(RD_CNT), 128'd0);
    check("stats_wr_cnt_reset", 128'(WR_CNT), 128'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
